vga_pmod_capture: RTL and testbench

Receive-side monitor for the TinyVGA PMOD bus. It takes the packed 8-bit PMOD output of a VGA generator and recovers hsync, vsync and the 2-bit R/G/B channels. It re-derives pixel coordinates from sync edges and emits a per-pixel sample stream, per-line and per-frame timing measurements, a per-frame pixel checksum and a lock indicator. It sits in loopback beside any pattern generator, either on-chip on `uo_out` or in simulation, for self-check and bring-up.

---
 rtl/vga_pmod_capture.sv | 199 +++++++++++++++++++
 tb/tb_vga_pmod_capture.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pmod_capture.sv
// Receive-side monitor for a TinyVGA PMOD bus: recovers syncs and colour, rebuilds
// pixel coordinates and reports line/frame timing, a per-frame checksum and lock.
module vga_pmod_capture #(
    parameter int H_OFFSET = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_OFFSET = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pmod_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [1:0]  pix_r,
    output logic [1:0]  pix_g,
    output logic [1:0]  pix_b,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [23:0] frame_sum,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic        locked,
    output logic        sync_err
);

    localparam logic [11:0] H_LO = 12'(H_OFFSET);
    localparam logic [11:0] H_HI = 12'(H_OFFSET + H_ACTIVE);
    localparam logic [10:0] V_LO = 11'(V_OFFSET);
    localparam logic [10:0] V_HI = 11'(V_OFFSET + V_ACTIVE);

    logic [7:0]  s1_q;
    logic        hs_prev_q, vs_prev_q;
    logic [5:0]  rgb_q, rgb_s;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic        ll_valid_q, ll_valid_d, mismatch_q, mismatch_d;
    logic [23:0] acc_q, acc_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [5:0]  pix_rgb_q, pix_rgb_d;
    logic [10:0] line_len_q, line_len_d;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic [23:0] frame_sum_q, frame_sum_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        locked_q, locked_d, sync_err_q, sync_err_d;

    logic        hs_s, vs_s, ha_s, va_s, timeout_s, meas_s, line_bad_s;
    logic        frame_end_s, win_s, mism_now_s;
    logic [10:0] meas_len_s;
    logic [9:0]  v_cnt_inc_s, counted_s;
    logic [23:0] acc_sum_s;

    assign hs_s  = s1_q[7];
    assign vs_s  = s1_q[3];
    assign rgb_s = {s1_q[0], s1_q[4], s1_q[1], s1_q[5], s1_q[2], s1_q[6]};
    assign ha_s  = hs_prev_q & ~hs_s;
    assign va_s  = vs_prev_q & ~vs_s;

    // Next-state logic for counters, timing measurement, checksum and pixel outputs.
    always_comb begin
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        h_seen_d    = h_seen_q;
        v_seen_d    = v_seen_q | va_s;
        timeout_s   = ~ha_s & (h_cnt_q == 11'h7FE);
        meas_s      = ha_s & h_seen_q;
        meas_len_s  = h_cnt_q + 11'd1;
        line_bad_s  = meas_s & ll_valid_q & (meas_len_s != line_len_q);
        ll_valid_d  = ll_valid_q | meas_s;
        line_len_d  = meas_s ? meas_len_s : line_len_q;
        v_cnt_inc_s = (v_cnt_q == 10'h3FF) ? v_cnt_q : v_cnt_q + 10'd1;
        // The HA coincident with a VA still belongs to the frame that is ending.
        counted_s   = ha_s ? v_cnt_inc_s : v_cnt_q;
        frame_end_s = va_s & v_seen_q;
        mism_now_s  = mismatch_q | line_bad_s;

        if (ha_s) begin
            h_cnt_d  = 11'd0;
            h_seen_d = 1'b1;
        end else if (h_cnt_q != 11'h7FF) begin
            h_cnt_d  = h_cnt_q + 11'd1;
            h_seen_d = timeout_s ? 1'b0 : h_seen_q;
        end else begin
            h_cnt_d  = h_cnt_q;
            h_seen_d = h_seen_q;
        end

        if (va_s) begin
            v_cnt_d = 10'd0;
        end else if (ha_s) begin
            v_cnt_d = v_cnt_inc_s;
        end else begin
            v_cnt_d = v_cnt_q;
        end

        // Window uses the stage-2 counters, which are aligned with rgb_q.
        win_s = h_seen_q & v_seen_q
              & ({1'b0, h_cnt_q} >= H_LO) & ({1'b0, h_cnt_q} < H_HI)
              & ({1'b0, v_cnt_q} >= V_LO) & ({1'b0, v_cnt_q} < V_HI);
        acc_sum_s   = acc_q + (win_s ? {18'd0, rgb_q} : 24'd0);
        pix_valid_d = win_s;
        pix_x_d     = win_s ? 10'(h_cnt_q - 11'(H_OFFSET)) : 10'd0;
        pix_y_d     = win_s ? 10'(v_cnt_q - 10'(V_OFFSET)) : 10'd0;
        pix_rgb_d   = win_s ? rgb_q : 6'd0;

        if (frame_end_s) begin
            acc_d         = 24'd0;
            mismatch_d    = 1'b0;
            frame_sum_d   = acc_sum_s;
            frame_lines_d = counted_s;
            frame_cnt_d   = frame_cnt_q + 8'd1;
        end else begin
            acc_d         = acc_sum_s;
            mismatch_d    = mism_now_s;
            frame_sum_d   = frame_sum_q;
            frame_lines_d = frame_lines_q;
            frame_cnt_d   = frame_cnt_q;
        end
        frame_done_d = frame_end_s;

        if (line_bad_s | timeout_s) begin
            locked_d = 1'b0;
        end else if (frame_end_s) begin
            locked_d = (counted_s == frame_lines_q) & ~mism_now_s & (counted_s != 10'd0);
        end else begin
            locked_d = locked_q;
        end
        sync_err_d = sync_err_q | line_bad_s | timeout_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= 8'd0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            rgb_q         <= 6'd0;
            h_cnt_q       <= 11'd0;
            v_cnt_q       <= 10'd0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            ll_valid_q    <= 1'b0;
            mismatch_q    <= 1'b0;
            acc_q         <= 24'd0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_rgb_q     <= 6'd0;
            line_len_q    <= 11'd0;
            frame_lines_q <= 10'd0;
            frame_sum_q   <= 24'd0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= 8'd0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            s1_q          <= pmod_in;
            hs_prev_q     <= hs_s;
            vs_prev_q     <= vs_s;
            rgb_q         <= rgb_s;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            ll_valid_q    <= ll_valid_d;
            mismatch_q    <= mismatch_d;
            acc_q         <= acc_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_rgb_q     <= pix_rgb_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            frame_sum_q   <= frame_sum_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_r       = pix_rgb_q[5:4];
    assign pix_g       = pix_rgb_q[3:2];
    assign pix_b       = pix_rgb_q[1:0];
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_sum   = frame_sum_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_pmod_capture.sv
// Directed bench for vga_pmod_capture using a miniature 16x8-clock raster
// (active 8x4 at offset 4,2) so whole frames stay short.
module tb_vga_pmod_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pmod_in;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic [1:0]  pix_r, pix_g, pix_b;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [23:0] frame_sum;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        locked, sync_err;

    int n_cmp = 0, n_bad = 0;
    int gx = 0, gy = 3, mode = 0;
    bit coin = 1'b0, stretch = 1'b0, stuck = 1'b0;
    int fd_cnt = 0, vld_cnt = 0, zero_err = 0;
    bit first_seen = 1'b0;
    int first_x = 0, first_y = 0, first_rgb = 0;
    int fd0;

    vga_pmod_capture #(.H_OFFSET(4), .H_ACTIVE(8), .V_OFFSET(2), .V_ACTIVE(4)) dut (
        .clk(clk), .rst_n(rst_n), .pmod_in(pmod_in),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .line_len(line_len), .frame_lines(frame_lines), .frame_sum(frame_sum),
        .frame_done(frame_done), .frame_cnt(frame_cnt),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One generator clock: drive the packed bus, wait an edge, observe, advance raster.
    task automatic tick();
        logic hs, vs;
        logic [1:0] r, g, b;
        int x, y, len;
        r = 2'd0; g = 2'd0; b = 2'd0;
        if (stuck) begin
            hs = 1'b1; vs = 1'b1;
        end else begin
            hs = (gx >= 2);
            vs = coin ? (gy != 0) : !((gy == 0 && gx >= 8) || (gy == 1 && gx < 8));
            if (gx >= 4 && gx < 12 && gy >= 2 && gy < 6) begin
                x = gx - 4; y = gy - 2;
                if (mode == 0) r = 2'd3;
                else if (((x ^ y) & 1) == 1) begin r = 2'd2; g = 2'd1; end
                else r = 2'd1;
            end
        end
        pmod_in = {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        if (pix_valid) begin
            vld_cnt++;
            if (!first_seen) begin
                first_seen = 1'b1;
                first_x = int'(pix_x); first_y = int'(pix_y);
                first_rgb = int'({pix_r, pix_g, pix_b});
            end
        end else if ((pix_x != 10'd0) || (pix_y != 10'd0) || ({pix_r, pix_g, pix_b} != 6'd0)) begin
            zero_err++;
        end
        if (!stuck) begin
            len = (stretch && gy == 3) ? 17 : 16;
            gx++;
            if (gx >= len) begin
                gx = 0;
                if (gy == 3) stretch = 1'b0;
                gy = (gy + 1) % 8;
            end
        end
    endtask

    task automatic wait_frame();
        int f0;
        f0 = fd_cnt; vld_cnt = 0; zero_err = 0; first_seen = 1'b0;
        for (int i = 0; i < 400 && fd_cnt == f0; i++) tick();
        if (fd_cnt == f0) check_val("frame_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_to(input int y, input int x);
        for (int i = 0; i < 400 && !(gx == x && gy == y); i++) tick();
        if (!(gx == x && gy == y)) check_val("run_to_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_zero(input string p);
        check_val({p, "_pix_valid"}, 32'(pix_valid), 32'd0);
        check_val({p, "_line_len"}, 32'(line_len), 32'd0);
        check_val({p, "_frame_lines"}, 32'(frame_lines), 32'd0);
        check_val({p, "_frame_sum"}, 32'(frame_sum), 32'd0);
        check_val({p, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check_val({p, "_locked"}, 32'(locked), 32'd0);
        check_val({p, "_sync_err"}, 32'(sync_err), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        pmod_in = 8'h88;
        repeat (4) tick();
        check_zero("rst");
        rst_n = 1'b1;

        // Solid red: 32 active pixels x 48 per frame.
        wait_frame();
        check_val("f1_line_len", 32'(line_len), 32'd16);
        check_val("f1_frame_lines", 32'(frame_lines), 32'd8);
        check_val("f1_frame_sum", 32'(frame_sum), 32'h600);
        check_val("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        check_val("f1_locked", 32'(locked), 32'd0);
        wait_frame();
        check_val("f2_locked", 32'(locked), 32'd1);
        check_val("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        check_val("f2_frame_sum", 32'(frame_sum), 32'h600);
        check_val("f2_valid_cnt", 32'(vld_cnt), 32'd32);
        check_val("f2_blank_zero", 32'(zero_err), 32'd0);
        tick();
        check_val("done_one_cycle", 32'(frame_done), 32'd0);

        // Dither: 16 x 36 + 16 x 16.
        mode = 1;
        wait_frame();
        check_val("dith_frame_sum", 32'(frame_sum), 32'h340);
        check_val("dith_valid_cnt", 32'(vld_cnt), 32'd32);
        check_val("dith_first_x", 32'(first_x), 32'd0);
        check_val("dith_first_y", 32'(first_y), 32'd0);
        check_val("dith_first_rgb", 32'(first_rgb), 32'd16);
        check_val("dith_blank_zero", 32'(zero_err), 32'd0);
        check_val("dith_frame_cnt", 32'(frame_cnt), 32'd3);
        check_val("dith_locked", 32'(locked), 32'd1);
        check_val("dith_sync_err", 32'(sync_err), 32'd0);

        // One line stretched to 17 clocks.
        stretch = 1'b1;
        run_to(4, 6);
        check_val("long_line_len", 32'(line_len), 32'd17);
        check_val("long_sync_err", 32'(sync_err), 32'd1);
        check_val("long_locked", 32'(locked), 32'd0);
        run_to(5, 6);
        check_val("long_next_len", 32'(line_len), 32'd16);
        wait_frame();
        check_val("long_f_locked", 32'(locked), 32'd0);
        check_val("long_f_lines", 32'(frame_lines), 32'd8);
        wait_frame();
        check_val("long_relock", 32'(locked), 32'd1);
        check_val("long_err_sticky", 32'(sync_err), 32'd1);

        // Asynchronous reset in the middle of an active row.
        run_to(4, 6);
        #3 rst_n = 1'b0;
        #1 check_zero("midrst");
        repeat (3) tick();
        rst_n = 1'b1;
        fd0 = fd_cnt;
        run_to(0, 12);
        check_val("midrst_no_done_va1", 32'(fd_cnt - fd0), 32'd0);
        wait_frame();
        check_val("midrst_frame_sum", 32'(frame_sum), 32'h340);
        check_val("midrst_frame_cnt", 32'(frame_cnt), 32'd1);
        check_val("midrst_frame_lines", 32'(frame_lines), 32'd8);
        wait_frame();
        check_val("midrst_locked", 32'(locked), 32'd1);
        check_val("midrst_sync_err", 32'(sync_err), 32'd0);

        // hsync stuck high well past the 2047 saturation point.
        stuck = 1'b1;
        repeat (1500) tick();
        check_val("stuck_early_err", 32'(sync_err), 32'd0);
        check_val("stuck_early_locked", 32'(locked), 32'd1);
        repeat (600) tick();
        check_val("stuck_sync_err", 32'(sync_err), 32'd1);
        check_val("stuck_locked", 32'(locked), 32'd0);
        check_val("stuck_pix_valid", 32'(pix_valid), 32'd0);
        stuck = 1'b0;

        // vsync and hsync asserting on the same clock.
        coin = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_frame();
        check_val("coin_frame_lines", 32'(frame_lines), 32'd8);
        check_val("coin_frame_sum", 32'(frame_sum), 32'h340);
        check_val("coin_frame_cnt", 32'(frame_cnt), 32'd1);
        wait_frame();
        check_val("coin_locked", 32'(locked), 32'd1);
        wait_frame();
        check_val("coin_keep_locked", 32'(locked), 32'd1);
        check_val("coin_frame_lines2", 32'(frame_lines), 32'd8);
        check_val("coin_frame_cnt3", 32'(frame_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
